// File: rtl/mmp_iddmm_arb_if.sv
// Multiplier-side bus of the IDDMM job scheduler: operand/modulus RAM writes
// toward the Montgomery multiplier and its task start/result/end handshake.
interface mmp_iddmm_arb_if #(
   parameter int K      = 128,
   parameter int N      = 32,
   parameter int ADDR_W = $clog2(N)
);
   logic [2:0]        mm_wr_ena;     // {m,y,x} write enables
   logic [ADDR_W-1:0] mm_wr_addr;
   logic [K-1:0]      mm_wr_x;
   logic [K-1:0]      mm_wr_y;
   logic [K-1:0]      mm_wr_m;
   logic [K-1:0]      mm_wr_m1;
   logic              mm_task_req;   // start pulse
   logic              mm_task_grant; // result word valid
   logic [K-1:0]      mm_task_res;
   logic              mm_task_end;   // multiplier done

   // Scheduler side
   modport master (
      output mm_wr_ena, mm_wr_addr, mm_wr_x, mm_wr_y, mm_wr_m, mm_wr_m1, mm_task_req,
      input  mm_task_grant, mm_task_res, mm_task_end
   );

   // Multiplier side
   modport slave (
      input  mm_wr_ena, mm_wr_addr, mm_wr_x, mm_wr_y, mm_wr_m, mm_wr_m1, mm_task_req,
      output mm_task_grant, mm_task_res, mm_task_end
   );
endinterface

// File: rtl/mmp_iddmm_arb.sv
// Round-robin scheduler sharing one Montgomery multiplier between two clients.
// Owns the modulus config path, streams the granted client's x/y operands into
// the multiplier RAMs, kicks the task and routes result words back to the owner.
module mmp_iddmm_arb #(
   parameter int K      = 128,
   parameter int N      = 32,
   parameter int ADDR_W = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst_n,
   // modulus configuration
   input  logic              cfg_wr_i,
   input  logic [ADDR_W-1:0] cfg_addr_i,
   input  logic [K-1:0]      cfg_m_i,
   input  logic [K-1:0]      cfg_m1_i,
   output logic              cfg_rdy_o,
   // clients
   input  logic              c0_req_i,
   input  logic              c1_req_i,
   output logic              c0_gnt_o,
   output logic              c1_gnt_o,
   output logic              c0_rd_en_o,
   output logic              c1_rd_en_o,
   output logic [ADDR_W-1:0] rd_addr_o,
   input  logic [K-1:0]      c0_rd_x_i,
   input  logic [K-1:0]      c0_rd_y_i,
   input  logic [K-1:0]      c1_rd_x_i,
   input  logic [K-1:0]      c1_rd_y_i,
   output logic [K-1:0]      res_data_o,
   output logic [ADDR_W-1:0] res_addr_o,
   output logic              c0_res_val_o,
   output logic              c1_res_val_o,
   output logic              c0_done_o,
   output logic              c1_done_o,
   output logic              c0_err_o,
   output logic              c1_err_o,
   // multiplier
   mmp_iddmm_arb_if.master   mm
);

   // Counters are one bit wider than an address so the value N fits.
   localparam int            CW  = ADDR_W + 1;
   localparam logic [CW-1:0] N_C = CW'(N);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_KICK, S_RUN} state_t;

   state_t            state_q;
   logic              cfg_rdy_q;
   logic [K-1:0]      m1_q;
   logic              last_q;      // last granted client
   logic              owner_q;     // client owning the current job
   logic [1:0]        gnt_q;
   logic [1:0]        rd_en_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [CW-1:0]     load_cnt_q;
   logic              wr_load_q;   // operand write cycle (rd_en delayed by one)
   logic [ADDR_W-1:0] wr_addr_q;
   logic              task_req_q;
   logic [K-1:0]      res_data_q;
   logic [ADDR_W-1:0] res_addr_q;
   logic [1:0]        res_val_q;
   logic [1:0]        done_q;
   logic [1:0]        err_q;
   logic [CW-1:0]     res_cnt_q;

   logic              cfg_acc;
   logic              gnt_vld_d;
   logic              owner_d;
   logic [CW-1:0]     res_cnt_d;
   logic [1:0]        own_vec;

   assign cfg_acc = cfg_wr_i & cfg_rdy_q;
   assign own_vec = owner_q ? 2'b10 : 2'b01;

   // Arbitration: config write wins the cycle, else round-robin on ties.
   always_comb begin
      // NOTE: defaults first so every path assigns and no latch is inferred.
      gnt_vld_d = 1'b0;
      owner_d   = 1'b0;
      if (state_q == S_IDLE && !cfg_acc) begin
         if (c0_req_i && c1_req_i) begin
            gnt_vld_d = 1'b1;
            owner_d   = ~last_q;
         end else if (c0_req_i || c1_req_i) begin
            gnt_vld_d = 1'b1;
            owner_d   = c1_req_i;
         end
      end
   end

   // Result count including a grant arriving this cycle, saturating at N.
   always_comb begin
      res_cnt_d = res_cnt_q;
      if (mm.mm_task_grant && res_cnt_q != N_C) res_cnt_d = res_cnt_q + CW'(1);
   end

   // Main FSM with registered client and multiplier-control outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cfg_rdy_q  <= 1'b0;
         m1_q       <= '0;
         last_q     <= 1'b1;
         owner_q    <= 1'b0;
         gnt_q      <= '0;
         rd_en_q    <= '0;
         rd_addr_q  <= '0;
         load_cnt_q <= '0;
         wr_load_q  <= 1'b0;
         wr_addr_q  <= '0;
         task_req_q <= 1'b0;
         res_data_q <= '0;
         res_addr_q <= '0;
         res_val_q  <= '0;
         done_q     <= '0;
         err_q      <= '0;
         res_cnt_q  <= '0;
      end else begin
         // NOTE: non-blocking throughout so every register samples pre-edge values.
         gnt_q      <= '0;
         task_req_q <= 1'b0;
         res_val_q  <= '0;
         done_q     <= '0;
         err_q      <= '0;
         unique case (state_q)
            S_IDLE: begin
               cfg_rdy_q <= 1'b1;
               if (cfg_acc) m1_q <= cfg_m1_i;
               if (gnt_vld_d) begin
                  state_q    <= S_LOAD;
                  cfg_rdy_q  <= 1'b0;
                  owner_q    <= owner_d;
                  last_q     <= owner_d;
                  gnt_q      <= owner_d ? 2'b10 : 2'b01;
                  rd_en_q    <= owner_d ? 2'b10 : 2'b01;
                  rd_addr_q  <= '0;
                  load_cnt_q <= '0;
               end
            end
            S_LOAD: begin
               wr_load_q  <= |rd_en_q;
               wr_addr_q  <= rd_addr_q;
               load_cnt_q <= load_cnt_q + CW'(1);
               if (load_cnt_q == N_C - CW'(1)) begin
                  rd_en_q   <= '0;
                  rd_addr_q <= '0;
               end else if (load_cnt_q < N_C - CW'(1)) begin
                  rd_addr_q <= rd_addr_q + ADDR_W'(1);
               end
               if (load_cnt_q == N_C) begin
                  state_q    <= S_KICK;
                  task_req_q <= 1'b1;
               end
            end
            S_KICK: state_q <= S_RUN;
            S_RUN: begin
               if (mm.mm_task_grant) begin
                  res_data_q <= mm.mm_task_res;
                  res_addr_q <= res_cnt_q[ADDR_W-1:0];
                  res_val_q  <= own_vec;
                  res_cnt_q  <= res_cnt_d;
               end
               if (mm.mm_task_end) begin
                  done_q    <= own_vec;
                  err_q     <= (res_cnt_d != N_C) ? own_vec : 2'b00;
                  res_cnt_q <= '0;
                  state_q   <= S_IDLE;
                  cfg_rdy_q <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign cfg_rdy_o    = cfg_rdy_q;
   assign c0_gnt_o     = gnt_q[0];
   assign c1_gnt_o     = gnt_q[1];
   assign c0_rd_en_o   = rd_en_q[0];
   assign c1_rd_en_o   = rd_en_q[1];
   assign rd_addr_o    = rd_addr_q;
   assign res_data_o   = res_data_q;
   assign res_addr_o   = res_addr_q;
   assign c0_res_val_o = res_val_q[0];
   assign c1_res_val_o = res_val_q[1];
   assign c0_done_o    = done_q[0];
   assign c1_done_o    = done_q[1];
   assign c0_err_o     = err_q[0];
   assign c1_err_o     = err_q[1];

   // Config writes pass straight through in IDLE; operand writes follow rd_en by one cycle.
   assign mm.mm_wr_ena   = wr_load_q ? 3'b011 : (cfg_acc ? 3'b100 : 3'b000);
   assign mm.mm_wr_addr  = wr_load_q ? wr_addr_q : (cfg_acc ? cfg_addr_i : '0);
   assign mm.mm_wr_x     = wr_load_q ? (owner_q ? c1_rd_x_i : c0_rd_x_i) : '0;
   assign mm.mm_wr_y     = wr_load_q ? (owner_q ? c1_rd_y_i : c0_rd_y_i) : '0;
   assign mm.mm_wr_m     = cfg_acc ? cfg_m_i : '0;
   // The multiplier latches wr_m1 on any write, so it is held at every write type.
   assign mm.mm_wr_m1    = m1_q;
   assign mm.mm_task_req = task_req_q;

endmodule

// File: tb/tb_mmp_iddmm_arb.sv
// Directed bench for mmp_iddmm_arb with N=4: config load, client jobs with
// cycle-exact timing, round-robin alternation, config collisions, short
// result error and reset in the middle of an operand load.
module tb_mmp_iddmm_arb;
   localparam int K      = 128;
   localparam int N      = 4;
   localparam int ADDR_W = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              cfg_wr;
   logic [ADDR_W-1:0] cfg_addr;
   logic [K-1:0]      cfg_m, cfg_m1;
   logic              cfg_rdy;
   logic              c0_req, c1_req, c0_gnt, c1_gnt, c0_rd_en, c1_rd_en;
   logic [ADDR_W-1:0] rd_addr, res_addr;
   logic [K-1:0]      c0_rd_x, c0_rd_y, c1_rd_x, c1_rd_y, res_data;
   logic              c0_res_val, c1_res_val, c0_done, c1_done, c0_err, c1_err;

   int total = 0;
   int bad   = 0;

   // client buffer model state: read strobe/address seen in the previous cycle
   logic              p0 = 1'b0, p1 = 1'b0;
   logic [ADDR_W-1:0] pa = '0;

   mmp_iddmm_arb_if #(.K(K), .N(N), .ADDR_W(ADDR_W)) mif ();

   mmp_iddmm_arb #(.K(K), .N(N), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_wr_i(cfg_wr), .cfg_addr_i(cfg_addr), .cfg_m_i(cfg_m), .cfg_m1_i(cfg_m1),
      .cfg_rdy_o(cfg_rdy),
      .c0_req_i(c0_req), .c1_req_i(c1_req), .c0_gnt_o(c0_gnt), .c1_gnt_o(c1_gnt),
      .c0_rd_en_o(c0_rd_en), .c1_rd_en_o(c1_rd_en), .rd_addr_o(rd_addr),
      .c0_rd_x_i(c0_rd_x), .c0_rd_y_i(c0_rd_y), .c1_rd_x_i(c1_rd_x), .c1_rd_y_i(c1_rd_y),
      .res_data_o(res_data), .res_addr_o(res_addr),
      .c0_res_val_o(c0_res_val), .c1_res_val_o(c1_res_val),
      .c0_done_o(c0_done), .c1_done_o(c1_done), .c0_err_o(c0_err), .c1_err_o(c1_err),
      .mm(mif)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [K-1:0] obs, input logic [K-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance to the next negedge; present operand data for last cycle's read.
   task automatic cyc();
      @(negedge clk);
      c0_rd_x = p0 ? K'(256 + pa)  : '0;
      c0_rd_y = p0 ? K'(512 + pa)  : '0;
      c1_rd_x = p1 ? K'(768 + pa)  : '0;
      c1_rd_y = p1 ? K'(1024 + pa) : '0;
      p0 = c0_rd_en;
      p1 = c1_rd_en;
      pa = rd_addr;
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_rdy"},  cfg_rdy, 0);
      check({tag, "_gnt"},  {c1_gnt, c0_gnt}, 0);
      check({tag, "_rden"}, {c1_rd_en, c0_rd_en}, 0);
      check({tag, "_ena"},  mif.mm_wr_ena, 0);
      check({tag, "_treq"}, mif.mm_task_req, 0);
      check({tag, "_val"},  {c1_res_val, c0_res_val}, 0);
      check({tag, "_done"}, {c1_done, c0_done, c1_err, c0_err}, 0);
      check({tag, "_m1"},   mif.mm_wr_m1, 0);
      check({tag, "_res"},  res_data, 0);
   endtask

   // Caller is in cycle t with the request(s) asserted. Returns in the done cycle.
   task automatic job(input int who, input int ngr, input bit collide);
      logic [1:0] own;
      own = (who == 1) ? 2'b10 : 2'b01;
      cyc(); // t+1
      check("gnt",     {c1_gnt, c0_gnt}, own);
      check("rden0",   {c1_rd_en, c0_rd_en}, own);
      check("rdaddr0", rd_addr, 0);
      check("ena_t1",  mif.mm_wr_ena, 0);
      check("rdy_ld",  cfg_rdy, 0);
      if (who == 1) c1_req = 1'b0; else c0_req = 1'b0;
      for (int k = 1; k <= N; k++) begin // t+1+k
         cyc();
         check("gnt_off", {c1_gnt, c0_gnt}, 0);
         check("rden",    {c1_rd_en, c0_rd_en}, (k < N) ? own : 2'b00);
         if (k < N) check("rdaddr", rd_addr, k);
         check("ena_ld",  mif.mm_wr_ena, 3'b011);
         check("wraddr",  mif.mm_wr_addr, k - 1);
         check("wr_x",    mif.mm_wr_x, K'((who == 1 ? 768 : 256) + k - 1));
         check("wr_y",    mif.mm_wr_y, K'((who == 1 ? 1024 : 512) + k - 1));
         check("treq_ld", mif.mm_task_req, 0);
      end
      cyc(); // t+N+2
      check("treq",     mif.mm_task_req, 1);
      check("ena_kick", mif.mm_wr_ena, 0);
      cyc(); // first RUN cycle
      check("treq_off", mif.mm_task_req, 0);
      if (collide) begin
         cfg_wr = 1'b1; cfg_addr = 2'd1; cfg_m = '1; cfg_m1 = K'(8'hCD);
         #1;
         check("run_rdy", cfg_rdy, 0);
         check("run_ena", mif.mm_wr_ena, 0);
         cyc();
         cfg_wr = 1'b0;
      end
      for (int w = 0; w < ngr; w++) begin
         mif.mm_task_grant = 1'b1;
         mif.mm_task_res   = K'(8'hA0 + w + who * 16);
         mif.mm_task_end   = (ngr == N) && (w == ngr - 1);
         cyc();
         check("res_val",  {c1_res_val, c0_res_val}, own);
         check("res_addr", res_addr, w);
         check("res_data", res_data, K'(8'hA0 + w + who * 16));
         check("done",     {c1_done, c0_done}, (ngr == N && w == ngr - 1) ? own : 2'b00);
         check("err",      {c1_err, c0_err}, 0);
      end
      mif.mm_task_grant = 1'b0;
      mif.mm_task_end   = 1'b0;
      if (ngr != N) begin
         mif.mm_task_end = 1'b1;
         cyc();
         mif.mm_task_end = 1'b0;
         check("sdone", {c1_done, c0_done}, own);
         check("serr",  {c1_err, c0_err}, own);
         check("sval",  {c1_res_val, c0_res_val}, 0);
      end
      check("rdy_done", cfg_rdy, 1);
   endtask

   initial begin
      rst_n = 1'b0; cfg_wr = 1'b1; cfg_addr = 2'd2; cfg_m = K'(8'h55); cfg_m1 = K'(8'h77);
      c0_req = 1'b0; c1_req = 1'b0;
      c0_rd_x = '0; c0_rd_y = '0; c1_rd_x = '0; c1_rd_y = '0;
      mif.mm_task_grant = 1'b0; mif.mm_task_res = '0; mif.mm_task_end = 1'b0;

      // reset state, with a config write attempt that must be ignored
      cyc(); cyc();
      check_quiet("rst");
      cfg_wr = 1'b0;
      rst_n  = 1'b1;
      cyc();
      check("rdy_idle", cfg_rdy, 1);

      // config load
      for (int i = 0; i < N; i++) begin
         cfg_wr = 1'b1; cfg_addr = ADDR_W'(i); cfg_m = K'(8'h11 * (i + 1)); cfg_m1 = K'(8'hAB);
         #1;
         check("cfg_ena",  mif.mm_wr_ena, 3'b100);
         check("cfg_addr", mif.mm_wr_addr, i);
         check("cfg_m",    mif.mm_wr_m, K'(8'h11 * (i + 1)));
         cyc();
      end
      cfg_wr = 1'b0;
      #1;
      check("cfg_ena_off", mif.mm_wr_ena, 0);
      check("cfg_m1",      mif.mm_wr_m1, K'(8'hAB));

      // single client-0 job, with a config write attempt during RUN
      c0_req = 1'b1;
      job(0, N, 1'b1);
      check("m1_hold", mif.mm_wr_m1, K'(8'hAB));

      // config write and c1_req in the same IDLE cycle, then a short result
      cyc();
      cfg_wr = 1'b1; cfg_addr = 2'd3; cfg_m = K'(8'h99); cfg_m1 = K'(8'hEF); c1_req = 1'b1;
      #1;
      check("col_ena", mif.mm_wr_ena, 3'b100);
      check("col_m",   mif.mm_wr_m, K'(8'h99));
      cyc();
      cfg_wr = 1'b0;
      check("col_nognt", {c1_gnt, c0_gnt}, 0);
      check("col_m1",    mif.mm_wr_m1, K'(8'hEF));
      job(1, 3, 1'b0);
      cyc();
      check("short_idle", cfg_rdy, 1);

      // arbitration: both requests held from reset, three alternating rounds
      rst_n = 1'b0; c0_req = 1'b1; c1_req = 1'b1;
      cyc();
      rst_n = 1'b1;
      for (int r = 0; r < 3; r++) begin
         job(0, N, 1'b0);
         c0_req = 1'b1;
         job(1, N, 1'b0);
         c1_req = 1'b1;
      end
      c1_req = 1'b0;

      // c0 still pending: reset at LOAD cycle 2 aborts the job
      cyc();
      check("arb_next", {c1_gnt, c0_gnt}, 2'b01);
      cyc(); cyc();
      rst_n = 1'b0;
      #1;
      check_quiet("midrst");
      cyc();
      check_quiet("midrst2");
      rst_n = 1'b1;
      job(0, N, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
